// File: rtl/pc_src_sel_ctrl.sv
// N-source PC byte-stream selector with frame-safe switching, test loopback
// and a saturating dropped-byte counter.
module pc_src_sel_ctrl #(
    parameter int unsigned U_DLY   = 1,
    parameter int unsigned N_SRC   = 3,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned KEY_SRC = 0,
    parameter int unsigned DEF_SRC = 1
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [N_SRC*8-1:0] src_rx_data,
    input  logic [N_SRC-1:0]   src_rx_valid,
    output logic [N_SRC-1:0]   src_tx_en,
    output logic [N_SRC*8-1:0] src_tx_data,
    input  logic [7:0]         mux_tx_data,
    input  logic               mux_tx_valid,
    output logic [7:0]         mux_rx_data,
    output logic               mux_rx_valid,
    input  logic               key_status,
    input  logic               key_valid,
    input  logic [2:0]         cmd_sel,
    input  logic               cmd_sel_valid,
    input  logic               test_mode,
    output logic [2:0]         cur_sel,
    output logic               switch_pending,
    output logic [15:0]        drop_cnt
);

    localparam logic [1:0]  StRun     = 2'd0;
    localparam logic [1:0]  StWaitGap = 2'd1;
    localparam logic [1:0]  StSwitch  = 2'd2;

    localparam logic [15:0] GapCyc = 16'(GAP_CYC);
    localparam logic [2:0]  KeySrc = 3'(KEY_SRC);
    localparam logic [2:0]  DefSrc = 3'(DEF_SRC);

    // U_DLY only models register delay in simulation; the logic does not use it.
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    logic [1:0]         state_q, state_d;
    logic [2:0]         cur_sel_q, cur_sel_d;
    logic [2:0]         rm_sel_q, rm_sel_d;
    logic [2:0]         req_sel_q, req_sel_d;
    logic               key_local_q, key_local_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]         mux_rx_data_q, mux_rx_data_d;
    logic               mux_rx_valid_q, mux_rx_valid_d;
    logic [N_SRC-1:0]   src_tx_en_q, src_tx_en_d;
    logic [N_SRC*8-1:0] src_tx_data_q, src_tx_data_d;

    logic               sel_rx_valid;
    logic [7:0]         sel_rx_data;
    logic [3:0]         drop_inc;
    logic [16:0]        drop_sum;

    // Slot selection and drop popcount, both against the pre-update cur_sel.
    always_comb begin
        sel_rx_valid = 1'b0;
        sel_rx_data  = 8'd0;
        drop_inc     = 4'd0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (3'(i) == cur_sel_q) begin
                sel_rx_valid = src_rx_valid[i];
                sel_rx_data  = src_rx_data[8*i +: 8];
            end
            if (src_rx_valid[i] && (test_mode || (3'(i) != cur_sel_q))) begin
                drop_inc = drop_inc + 4'd1;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_inc);

    always_comb begin
        key_local_d = key_valid ? ~key_status : key_local_q;
        rm_sel_d    = rm_sel_q;
        if (cmd_sel_valid && ({29'd0, cmd_sel} < N_SRC)) begin
            rm_sel_d = cmd_sel;
        end
        req_sel_d  = key_local_q ? KeySrc : rm_sel_q;
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        if (sel_rx_valid || mux_tx_valid) begin
            gap_cnt_d = 16'd0;
        end else if (gap_cnt_q == GapCyc) begin
            gap_cnt_d = gap_cnt_q;
        end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
        end
        case (state_q)
            StRun: begin
                if (req_sel_q != cur_sel_q) state_d = StWaitGap;
            end
            StWaitGap: begin
                if (req_sel_q == cur_sel_q) begin
                    state_d = StRun;
                end else if (gap_cnt_q == GapCyc) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                // Newest request wins, even if it changed on the last gap cycle.
                cur_sel_d = req_sel_q;
                gap_cnt_d = 16'd0;
                state_d   = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        src_tx_en_d   = '0;
        src_tx_data_d = '0;
        if (test_mode) begin
            mux_rx_valid_d = mux_tx_valid;
            mux_rx_data_d  = mux_tx_data;
        end else begin
            mux_rx_valid_d = sel_rx_valid;
            mux_rx_data_d  = sel_rx_data;
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (3'(i) == cur_sel_q) begin
                    src_tx_en_d[i]          = mux_tx_valid;
                    src_tx_data_d[8*i +: 8] = mux_tx_data;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q        <= StRun;
            cur_sel_q      <= DefSrc;
            rm_sel_q       <= DefSrc;
            req_sel_q      <= DefSrc;
            key_local_q    <= 1'b0;
            gap_cnt_q      <= 16'd0;
            drop_cnt_q     <= 16'd0;
            mux_rx_data_q  <= 8'd0;
            mux_rx_valid_q <= 1'b0;
            src_tx_en_q    <= '0;
            src_tx_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cur_sel_q      <= cur_sel_d;
            rm_sel_q       <= rm_sel_d;
            req_sel_q      <= req_sel_d;
            key_local_q    <= key_local_d;
            gap_cnt_q      <= gap_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            mux_rx_data_q  <= mux_rx_data_d;
            mux_rx_valid_q <= mux_rx_valid_d;
            src_tx_en_q    <= src_tx_en_d;
            src_tx_data_q  <= src_tx_data_d;
        end
    end

    assign cur_sel        = cur_sel_q;
    assign switch_pending = (state_q != StRun);
    assign drop_cnt       = drop_cnt_q;
    assign mux_rx_data    = mux_rx_data_q;
    assign mux_rx_valid   = mux_rx_valid_q;
    assign src_tx_en      = src_tx_en_q;
    assign src_tx_data    = src_tx_data_q;

endmodule

// File: tb/tb_pc_src_sel_ctrl.sv
// Self-checking bench for pc_src_sel_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the selector.
module tb_pc_src_sel_ctrl;

    localparam int N = 3;
    localparam int G = 16;

    logic           clk_sys = 1'b0;
    logic           rst;
    logic [N*8-1:0] src_rx_data;
    logic [N-1:0]   src_rx_valid;
    logic [N-1:0]   src_tx_en;
    logic [N*8-1:0] src_tx_data;
    logic [7:0]     mux_tx_data;
    logic           mux_tx_valid;
    logic [7:0]     mux_rx_data;
    logic           mux_rx_valid;
    logic           key_status;
    logic           key_valid;
    logic [2:0]     cmd_sel;
    logic           cmd_sel_valid;
    logic           test_mode;
    logic [2:0]     cur_sel;
    logic           switch_pending;
    logic [15:0]    drop_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who is selected, who is wanted, and whether a switch
    // is waiting for a quiet line or happens on this very cycle.
    int             m_cur, m_rm, m_req, m_gap, m_drop;
    bit             m_key_local, m_waiting, m_switching;
    bit             m_rx_v;
    logic [7:0]     m_rx_d;
    logic [N-1:0]   m_tx_en;
    logic [N*8-1:0] m_tx_vec;

    pc_src_sel_ctrl #(
        .U_DLY  (1),
        .N_SRC  (N),
        .GAP_CYC(G),
        .KEY_SRC(0),
        .DEF_SRC(1)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .src_rx_data   (src_rx_data),
        .src_rx_valid  (src_rx_valid),
        .src_tx_en     (src_tx_en),
        .src_tx_data   (src_tx_data),
        .mux_tx_data   (mux_tx_data),
        .mux_tx_valid  (mux_tx_valid),
        .mux_rx_data   (mux_rx_data),
        .mux_rx_valid  (mux_rx_valid),
        .key_status    (key_status),
        .key_valid     (key_valid),
        .cmd_sel       (cmd_sel),
        .cmd_sel_valid (cmd_sel_valid),
        .test_mode     (test_mode),
        .cur_sel       (cur_sel),
        .switch_pending(switch_pending),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic idle_inputs();
        src_rx_data   = '0;
        src_rx_valid  = '0;
        mux_tx_data   = 8'd0;
        mux_tx_valid  = 1'b0;
        key_status    = 1'b1;
        key_valid     = 1'b0;
        cmd_sel       = 3'd0;
        cmd_sel_valid = 1'b0;
        test_mode     = 1'b0;
    endtask

    // Advance the model on the current inputs, then clock the DUT and settle.
    task automatic step();
        int  drops;
        bit  busy;
        if (rst) begin
            m_cur = 1; m_rm = 1; m_req = 1; m_gap = 0; m_drop = 0;
            m_key_local = 0; m_waiting = 0; m_switching = 0;
            m_rx_v = 0; m_rx_d = 8'd0; m_tx_en = '0; m_tx_vec = '0;
        end else begin
            m_rx_v   = test_mode ? mux_tx_valid : src_rx_valid[m_cur];
            m_rx_d   = test_mode ? mux_tx_data : src_rx_data[8*m_cur +: 8];
            m_tx_en  = '0;
            m_tx_vec = '0;
            if (!test_mode) begin
                m_tx_en[m_cur]          = mux_tx_valid;
                m_tx_vec[8*m_cur +: 8]  = mux_tx_data;
            end
            drops = 0;
            for (int i = 0; i < N; i++)
                if (src_rx_valid[i] && (test_mode || i != m_cur)) drops++;
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
            busy = src_rx_valid[m_cur] || mux_tx_valid;
            if (m_switching) begin
                m_cur = m_req;
                m_gap = 0;
                m_switching = 0;
            end else begin
                if (!m_waiting) begin
                    m_waiting = (m_req != m_cur);
                end else if (m_req == m_cur) begin
                    m_waiting = 0;
                end else if (m_gap == G) begin
                    m_waiting = 0;
                    m_switching = 1;
                end
                m_gap = busy ? 0 : ((m_gap < G) ? m_gap + 1 : G);
            end
            m_req = m_key_local ? 0 : m_rm;
            if (key_valid) m_key_local = !key_status;
            if (cmd_sel_valid && int'(cmd_sel) < N) m_rm = int'(cmd_sel);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if (cur_sel !== 3'd1) begin
            errors++; $display("FAIL reset_cur got=%0d exp=1", cur_sel);
        end
        checks++;
        if ({src_tx_en, src_tx_data, mux_rx_data, mux_rx_valid, switch_pending, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outs got tx_en=%b rx_v=%b pend=%b drop=%0d exp all zero",
                     src_tx_en, mux_rx_valid, switch_pending, drop_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_upstream();
        src_rx_valid = 3'b010;
        src_rx_data  = 24'h00_5A_00;
        step();
        idle_inputs();
        checks++;
        if (mux_rx_valid !== 1'b1 || mux_rx_data !== 8'h5A) begin
            errors++; $display("FAIL up_byte got v=%b d=%h exp v=1 d=5a", mux_rx_valid, mux_rx_data);
        end
        checks++;
        if (cur_sel !== 3'd1 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL up_state got cur=%0d drop=%0d exp cur=1 drop=0", cur_sel, drop_cnt);
        end
        step();
        checks++;
        if (mux_rx_valid !== 1'b0) begin
            errors++; $display("FAIL up_idle got v=%b exp v=0", mux_rx_valid);
        end
    endtask

    task automatic test_gap_switch();
        int k;
        cmd_sel = 3'd2; cmd_sel_valid = 1'b1;
        step();
        idle_inputs();
        for (int b = 0; b < 10; b++) begin
            src_rx_valid = 3'b010;
            src_rx_data  = {8'h00, 8'(b), 8'h00};
            step();
            idle_inputs();
            if (b != 9) begin
                step(); step(); step();
            end
        end
        checks++;
        if (switch_pending !== 1'b1 || cur_sel !== 3'd1) begin
            errors++; $display("FAIL gap_hold got pend=%b cur=%0d exp pend=1 cur=1", switch_pending, cur_sel);
        end
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (cur_sel == 3'd2) begin k = c; break; end
        end
        checks++;
        if (k != G + 2) begin
            errors++; $display("FAIL gap_latency got=%0d exp=%0d cycles", k, G + 2);
        end
        step();
        checks++;
        if (switch_pending !== 1'b0) begin
            errors++; $display("FAIL gap_done got pend=%b exp 0", switch_pending);
        end
    endtask

    task automatic test_key();
        bit hit;
        key_valid = 1'b1; key_status = 1'b0;
        step();
        idle_inputs();
        cmd_sel = 3'd1; cmd_sel_valid = 1'b1;
        step();
        idle_inputs();
        hit = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (cur_sel == 3'd0) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL key_local got cur=%0d exp 0", cur_sel);
        end
        for (int c = 0; c < 40; c++) step();
        checks++;
        if (cur_sel !== 3'd0 || switch_pending !== 1'b0) begin
            errors++; $display("FAIL key_hold got cur=%0d pend=%b exp cur=0 pend=0", cur_sel, switch_pending);
        end
        key_valid = 1'b1; key_status = 1'b1;
        step();
        idle_inputs();
        hit = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (cur_sel == 3'd1) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL key_remote got cur=%0d exp 1", cur_sel);
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_cancel();
        // Keep the selected source busy so the gap never completes.
        src_rx_valid = 3'b010;
        cmd_sel = 3'd2; cmd_sel_valid = 1'b1;
        step();
        cmd_sel_valid = 1'b0;
        step(); step();
        checks++;
        if (switch_pending !== 1'b1) begin
            errors++; $display("FAIL cancel_wait got pend=%b exp 1", switch_pending);
        end
        cmd_sel = 3'd1; cmd_sel_valid = 1'b1;
        step();
        cmd_sel_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (switch_pending !== 1'b0 || cur_sel !== 3'd1) begin
            errors++; $display("FAIL cancel_run got pend=%b cur=%0d exp pend=0 cur=1", switch_pending, cur_sel);
        end
        idle_inputs();
        cmd_sel = 3'd7; cmd_sel_valid = 1'b1;
        step();
        idle_inputs();
        for (int c = 0; c < 30; c++) step();
        checks++;
        if (switch_pending !== 1'b0 || cur_sel !== 3'd1) begin
            errors++; $display("FAIL cancel_oor got pend=%b cur=%0d exp pend=0 cur=1", switch_pending, cur_sel);
        end
    endtask

    task automatic test_loopback();
        mux_tx_valid = 1'b1; mux_tx_data = 8'hA5;
        step();
        checks++;
        if (src_tx_en !== 3'b010 || src_tx_data !== 24'h00_A5_00) begin
            errors++; $display("FAIL tx_route got en=%b data=%h exp en=010 data=00a500", src_tx_en, src_tx_data);
        end
        test_mode = 1'b1;
        step();
        checks++;
        if (mux_rx_valid !== 1'b1 || mux_rx_data !== 8'hA5 || src_tx_en !== 3'b000) begin
            errors++;
            $display("FAIL loopback got rx_v=%b rx_d=%h en=%b exp rx_v=1 rx_d=a5 en=000",
                     mux_rx_valid, mux_rx_data, src_tx_en);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(999) < 2);
            for (int i = 0; i < N; i++) src_rx_valid[i] = ($urandom_range(99) < 5);
            src_rx_data   = 24'($urandom);
            mux_tx_valid  = ($urandom_range(99) < 5);
            mux_tx_data   = 8'($urandom);
            key_valid     = ($urandom_range(99) < 2);
            key_status    = ($urandom_range(99) < 60);
            cmd_sel_valid = ($urandom_range(99) < 3);
            cmd_sel       = 3'($urandom_range(7));
            if ($urandom_range(99) < 1) test_mode = ~test_mode;
            step();
            checks++;
            if (cur_sel !== 3'(m_cur) || switch_pending !== (m_waiting || m_switching)) begin
                errors++;
                $display("FAIL rnd_sel cyc=%0d got cur=%0d pend=%b exp cur=%0d pend=%b",
                         c, cur_sel, switch_pending, m_cur, m_waiting || m_switching);
            end
            checks++;
            if (mux_rx_valid !== m_rx_v || mux_rx_data !== m_rx_d) begin
                errors++;
                $display("FAIL rnd_rx cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         c, mux_rx_valid, mux_rx_data, m_rx_v, m_rx_d);
            end
            checks++;
            if (src_tx_en !== m_tx_en || src_tx_data !== m_tx_vec) begin
                errors++;
                $display("FAIL rnd_tx cyc=%0d got en=%b d=%h exp en=%b d=%h",
                         c, src_tx_en, src_tx_data, m_tx_en, m_tx_vec);
            end
            checks++;
            if (drop_cnt !== 16'(m_drop)) begin
                errors++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", c, drop_cnt, m_drop);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_drop_sat();
        rst = 1'b1;
        step();
        rst = 1'b0;
        src_rx_valid = 3'b101;
        for (int c = 0; c < 40000; c++) begin
            src_rx_data = 24'($urandom);
            step();
        end
        checks++;
        if (drop_cnt !== 16'hFFFF || m_drop != 65535) begin
            errors++; $display("FAIL drop_sat got=%h exp=ffff", drop_cnt);
        end
        checks++;
        if (cur_sel !== 3'd1 || mux_rx_valid !== 1'b0) begin
            errors++; $display("FAIL drop_sel got cur=%0d rx_v=%b exp cur=1 rx_v=0", cur_sel, mux_rx_valid);
        end
        mux_tx_valid = 1'b1; mux_tx_data = 8'h3C;
        src_rx_valid = 3'b111;
        rst = 1'b1;
        step();
        checks++;
        if (cur_sel !== 3'd1 || {src_tx_en, src_tx_data, mux_rx_data, mux_rx_valid,
                                 switch_pending, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset got cur=%0d en=%b rx_v=%b drop=%0d exp cur=1 rest zero",
                     cur_sel, src_tx_en, mux_rx_valid, drop_cnt);
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_upstream();
        test_gap_switch();
        test_key();
        test_cancel();
        test_loopback();
        test_random();
        test_drop_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
